// File: rtl/skid_fifo_pkg.sv
// Shared helpers for skid_fifo: width functions and parameter legality checks.
package skid_fifo_pkg;

  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // A one-entry ring still needs a 1-bit pointer so the vector is never empty.
  function automatic int ptr_width(input int entries);
    return (entries <= 2) ? 1 : $clog2(entries);
  endfunction

  function automatic bit depth_legal(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit thresh_legal(input int depth, input int thresh);
    return (thresh >= 1) && (thresh <= depth);
  endfunction

endpackage

// File: rtl/skid_fifo_ring.sv
// Circular storage behind the skid_fifo output register; pointers wrap at ENTRIES,
// which need not be a power of two.
module skid_fifo_ring
  import skid_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ENTRIES    = 3
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           clear_i,
  input  logic                           push_i,
  input  logic                           pop_i,
  input  logic [DATA_WIDTH-1:0]          wdata_i,
  output logic [DATA_WIDTH-1:0]          rdata_o,
  output logic                           empty_o,
  output logic [$clog2(ENTRIES+1)-1:0]   count_o
);

  localparam int PW = ptr_width(ENTRIES);
  localparam int CW = $clog2(ENTRIES + 1);

  logic [DATA_WIDTH-1:0] mem_q [ENTRIES];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(ENTRIES - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop_i)  rd_ptr_d = next_ptr(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/skid_fifo.sv
// DEPTH-beat valid/ready buffer: output register plus a (DEPTH-1)-entry ring, all outputs
// registered. Define SKID_FIFO_FLUSH_EN to enable the synchronous flush input.
module skid_fifo
  import skid_fifo_pkg::*;
#(
  parameter int DATA_WIDTH         = 32,
  parameter int DEPTH              = 4,
  parameter int ALMOST_FULL_THRESH = DEPTH - 1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  input  logic                            flush,
  output logic [$clog2(DEPTH+1)-1:0]      level,
  output logic                            almost_full
);

  localparam int LW = level_width(DEPTH);
  localparam int CW = $clog2(DEPTH);

  if (!depth_legal(DEPTH)) begin : g_bad_depth
    $error("skid_fifo: DEPTH must be a power of two and at least 2");
  end
  if (!thresh_legal(DEPTH, ALMOST_FULL_THRESH)) begin : g_bad_thresh
    $error("skid_fifo: ALMOST_FULL_THRESH must lie in 1..DEPTH");
  end
  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("skid_fifo: DATA_WIDTH must be at least 1");
  end

  logic                  flush_act;
`ifdef SKID_FIFO_FLUSH_EN
  assign flush_act = flush;
`else
  logic unused_flush;
  assign flush_act    = 1'b0;
  assign unused_flush = flush;
`endif

  logic [LW-1:0]         level_q, level_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  almost_full_q, almost_full_d;
  logic                  reset_hold_q;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic                  rx, tx, out_load;
  logic                  ring_push, ring_pop, ring_empty;
  logic [DATA_WIDTH-1:0] ring_rdata;
  logic [CW-1:0]         ring_count_unused;

  assign rx       = in_valid && in_ready_q;
  assign tx       = out_valid_q && out_ready;
  assign out_load = !out_valid_q || tx;

  // Beats go straight to the output register only when it frees up and nothing is queued ahead.
  assign ring_pop  = out_load && !ring_empty && !flush_act;
  assign ring_push = rx && !flush_act && (!out_load || !ring_empty);

  skid_fifo_ring #(
    .DATA_WIDTH (DATA_WIDTH),
    .ENTRIES    (DEPTH - 1)
  ) u_ring (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (flush_act),
    .push_i  (ring_push),
    .pop_i   (ring_pop),
    .wdata_i (in_data),
    .rdata_o (ring_rdata),
    .empty_o (ring_empty),
    .count_o (ring_count_unused)
  );

  always_comb begin
    level_d = level_q + LW'(rx) - LW'(tx);
    if (flush_act) level_d = '0;
    in_ready_d    = (level_d != LW'(DEPTH)) && !reset_hold_q;
    out_valid_d   = (level_d != '0);
    almost_full_d = (level_d >= LW'(ALMOST_FULL_THRESH));

    out_data_d = out_data_q;
    if (!flush_act && out_load) begin
      if (!ring_empty) out_data_d = ring_rdata;
      else if (rx)     out_data_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q       <= '0;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      almost_full_q <= 1'b0;
      reset_hold_q  <= 1'b1;
    end else begin
      level_q       <= level_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      almost_full_q <= almost_full_d;
      reset_hold_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    out_data_q <= out_data_d;
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign level       = level_q;
  assign almost_full = almost_full_q;

endmodule

// File: tb/tb_skid_fifo.sv
// Self-checking bench for skid_fifo (DATA_WIDTH=8, DEPTH=4) against a queue-based model.
module tb_skid_fifo;

  logic       clk;
  logic       reset_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       flush;
  logic [2:0] level;
  logic       almost_full;

  int vectors;
  int miscompares;

  logic [7:0] mq[$];
  bit         m_hold;
  bit         m_in_ready;
  int         m_accepted;

  skid_fifo #(
    .DATA_WIDTH (8),
    .DEPTH      (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .flush       (flush),
    .level       (level),
    .almost_full (almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    m_hold     = 1'b1;
    m_in_ready = 1'b0;
  endtask

  // One rising edge: the model consumes the inputs that were stable before it.
  task automatic step();
    bit rx, tx, fl;
    @(posedge clk);
    rx = in_valid && m_in_ready;
    tx = (mq.size() != 0) && out_ready;
`ifdef SKID_FIFO_FLUSH_EN
    fl = flush;
`else
    fl = 1'b0;
`endif
    if (fl) begin
      mq.delete();
    end else begin
      if (tx) void'(mq.pop_front());
      if (rx) begin
        mq.push_back(in_data);
        m_accepted++;
      end
    end
    m_in_ready = (mq.size() != 4) && !m_hold;
    m_hold     = 1'b0;
    #1;
  endtask

  task automatic hard_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    step();
    step();
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    out_ready = 1'b0;
    flush     = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || level !== 3'd0 || almost_full !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: in_ready=%b out_valid=%b level=%0d af=%b, required 0 0 0 0",
               in_ready, out_valid, level, almost_full);
    end
    reset_n = 1'b1;
    step();
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || level !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_edge1: in_ready=%b out_valid=%b level=%0d, required 0 0 0",
               in_ready, out_valid, level);
    end
    step();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || level !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_edge2: in_ready=%b out_valid=%b level=%0d, required 1 0 0",
               in_ready, out_valid, level);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_fill();
    logic [7:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = vals[i];
      step();
      vectors++;
      if (level !== 3'(i + 1) || almost_full !== (i + 1 >= 3) || in_ready !== (i + 1 != 4)
          || out_valid !== 1'b1 || out_data !== 8'h11) begin
        miscompares++;
        $display("FAIL fill_%0d: level=%0d af=%b in_ready=%b out_valid=%b data=%h, required %0d %b %b 1 11",
                 i, level, almost_full, in_ready, out_valid, out_data,
                 i + 1, (i + 1 >= 3), (i + 1 != 4));
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_drain();
    logic [7:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_data !== vals[i]) begin
        miscompares++;
        $display("FAIL drain_data_%0d: out_valid=%b data=%h, required 1 %h", i, out_valid, out_data, vals[i]);
      end
      step();
      vectors++;
      if (in_ready !== 1'b1 || level !== 3'(3 - i)) begin
        miscompares++;
        $display("FAIL drain_level_%0d: in_ready=%b level=%0d, required 1 %0d", i, in_ready, level, 3 - i);
      end
    end
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_empty: out_valid=%b, required 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 64; i++) begin
      in_data = 8'(i);
      step();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 8'(i) || level !== 3'd1 || in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL stream_%0d: out_valid=%b data=%h level=%0d in_ready=%b, required 1 %h 1 1",
                 i, out_valid, out_data, level, in_ready, 8'(i));
      end
    end
    in_valid = 1'b0;
    step();
    vectors++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      miscompares++;
      $display("FAIL stream_end: out_valid=%b level=%0d, required 0 0", out_valid, level);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random_stall();
    int         cycles;
    int         target;
    bit         pv, pr;
    logic [7:0] pd;
    target = m_accepted + 200;
    cycles = 0;
    while (m_accepted < target && cycles < 4000) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 50);
      in_data   = 8'($urandom);
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
      step();
      cycles++;
      vectors++;
      if (level !== 3'(mq.size()) || level > 3'd4 || out_valid !== (mq.size() != 0)
          || in_ready !== m_in_ready || almost_full !== (mq.size() >= 3)) begin
        miscompares++;
        $display("FAIL rnd_ctrl_c%0d: level=%0d out_valid=%b in_ready=%b af=%b, required %0d %b %b %b",
                 cycles, level, out_valid, in_ready, almost_full,
                 mq.size(), (mq.size() != 0), m_in_ready, (mq.size() >= 3));
      end
      if (mq.size() != 0) begin
        vectors++;
        if (out_data !== mq[0]) begin
          miscompares++;
          $display("FAIL rnd_order_c%0d: out_data=%h, required %h", cycles, out_data, mq[0]);
        end
      end
      if (pv && !pr) begin
        vectors++;
        if (out_data !== pd) begin
          miscompares++;
          $display("FAIL rnd_stable_c%0d: out_data=%h, required %h", cycles, out_data, pd);
        end
      end
    end
    vectors++;
    if (m_accepted < target) begin
      miscompares++;
      $display("FAIL rnd_timeout: accepted %0d, required %0d", m_accepted, target);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic fill_three();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'hC0 + 8'(i);
      step();
    end
    in_valid = 1'b0;
    vectors++;
    if (level !== 3'd3) begin
      miscompares++;
      $display("FAIL setup_level3: level=%0d, required 3", level);
    end
  endtask

  task automatic test_flush();
    hard_reset();
    fill_three();
`ifdef SKID_FIFO_FLUSH_EN
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    vectors++;
    if (level !== 3'd0 || out_valid !== 1'b0 || almost_full !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_clear: level=%0d out_valid=%b af=%b, required 0 0 0", level, out_valid, almost_full);
    end
    in_valid = 1'b1;
    in_data  = 8'h5A;
    step();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 8'h5A || level !== 3'd1) begin
      miscompares++;
      $display("FAIL flush_after: out_valid=%b data=%h level=%0d, required 1 5a 1", out_valid, out_data, level);
    end
`else
    flush = 1'b1;
    step();
    flush = 1'b0;
    vectors++;
    if (level !== 3'd3 || out_valid !== 1'b1 || out_data !== 8'hC0) begin
      miscompares++;
      $display("FAIL flush_ignored: level=%0d out_valid=%b data=%h, required 3 1 c0", level, out_valid, out_data);
    end
`endif
  endtask

  task automatic test_reset_midway();
    hard_reset();
    fill_three();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    #3 reset_n = 1'b0;
    #1;
    vectors++;
    if (level !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b0 || almost_full !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: level=%0d out_valid=%b in_ready=%b af=%b, required 0 0 0 0",
               level, out_valid, in_ready, almost_full);
    end
    model_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    step();
    step();
    vectors++;
    if (in_ready !== 1'b1 || level !== 3'd0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_recover: in_ready=%b level=%0d out_valid=%b, required 1 0 0", in_ready, level, out_valid);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_accepted  = 0;
    reset_n     = 1'b0;
    in_data     = '0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    flush       = 1'b0;
    model_reset();

    test_reset();
    test_fill();
    test_drain();
    test_streaming();
    test_random_stall();
    test_flush();
    test_reset_midway();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
